pipe_dff_en: RTL and testbench

//  Parametrised elastic register pipeline; successor of the single-bit enabled flop.

---
 rtl/pipe_dff_pkg.sv | 16 +
 rtl/pipe_dff_stage.sv | 35 +++
 rtl/pipe_dff_en.sv | 98 +++++++++
 tb/tb_pipe_dff_en.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_dff_pkg.sv
// Shared types and helpers for the pipe_dff elastic register pipeline.
// The optional occupancy counter in pipe_dff_en is enabled by defining PIPE_DFF_OCC_EN.
package pipe_dff_pkg;

  // Valid/ready pair reused by other elastic blocks.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Width of a counter that must hold 0..stages inclusive.
  function automatic int occ_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_dff_stage.sv
// One pipeline stage: WIDTH-bit enabled data register plus its valid flop.
// Flush clears the valid bit only; the data register keeps its value.
module pipe_dff_stage
  import pipe_dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d,
  output logic             v,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      q <= RESET_VAL;
    end else begin
      if (flush) begin
        v <= 1'b0;
      end else if (en) begin
        v <= v_in;
      end
      if (en && !flush) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/pipe_dff_en.sv
// Elastic STAGES-deep register pipeline with bubble collapsing and synchronous flush.
// Define PIPE_DFF_OCC_EN to add the registered occupancy output.
module pipe_dff_en
  import pipe_dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready
`ifdef PIPE_DFF_OCC_EN
  ,
  output logic [occ_width(STAGES)-1:0]  occupancy
`endif
);

  // Handshake: a word moves across a port on a rising edge exactly when valid and
  // ready are both high in the preceding cycle; valid never depends on ready, and
  // in_ready depends on out_ready and pipeline state only, never on in_valid.

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0]            v_src;
  logic [STAGES-1:0][WIDTH-1:0] d_src;
  logic [STAGES-1:0][WIDTH-1:0] q;
  hs_t                          in_hs;
  hs_t                          out_hs;
  logic                         in_fire;
  logic                         out_fire;

  assign in_hs    = '{valid: in_valid, ready: in_ready};
  assign out_hs   = '{valid: out_valid, ready: out_ready};
  assign in_fire  = in_hs.valid & in_hs.ready;
  assign out_fire = out_hs.valid & out_hs.ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // Stage i may load when any stage from i to the output is empty, or the
    // consumer drains this cycle; this is the unrolled bubble-collapse chain.
    assign adv[i] = out_ready | ~(&v[STAGES-1:i]);

    if (i == 0) begin : g_head
      assign v_src[i] = in_fire;
      assign d_src[i] = in_data;
    end else begin : g_body
      assign v_src[i] = v[i-1];
      assign d_src[i] = q[i-1];
    end

    pipe_dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .en    (adv[i]),
      .v_in  (v_src[i]),
      .d     (d_src[i]),
      .v     (v[i]),
      .q     (q[i])
    );
  end

  assign in_ready  = adv[0] & ~flush & ~rst;
  assign out_valid = v[STAGES-1];
  assign out_data  = q[STAGES-1];

`ifdef PIPE_DFF_OCC_EN
  localparam int OCC_W = occ_width(STAGES);

  logic [OCC_W-1:0] occ;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign occupancy = occ;
`else
  // No occupancy tracking in this build.
`endif

endmodule

// File: tb/tb_pipe_dff_en.sv
// Bench for pipe_dff_en: three instances (STAGES=2,4,1) share one stimulus stream and
// are checked each cycle against a word/position model, plus tables and directed cases.
module tb_pipe_dff_en;

  localparam logic [7:0] RV = 8'hC3;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];
`ifdef PIPE_DFF_OCC_EN
  logic [1:0] occ_a;
  logic [2:0] occ_b;
  logic [0:0] occ_c;
`endif

  int checks   = 0;
  int failures = 0;

  // Sampled outputs of the most recent cycle.
  logic       s_ir [3];
  logic       s_ov [3];
  logic [7:0] s_od [3];

  // Model: words oldest first, each with its stage position.
  int         m_n   [3];
  int         m_pos [3][4];
  logic [7:0] m_dat [3][4];
  logic [7:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  pipe_dff_en #(.WIDTH(8), .STAGES(2), .RESET_VAL(RV)) u_s2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready)
`ifdef PIPE_DFF_OCC_EN
    , .occupancy(occ_a)
`endif
  );

  pipe_dff_en #(.WIDTH(8), .STAGES(4), .RESET_VAL(RV)) u_s4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready)
`ifdef PIPE_DFF_OCC_EN
    , .occupancy(occ_b)
`endif
  );

  pipe_dff_en #(.WIDTH(8), .STAGES(1), .RESET_VAL(RV)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready)
`ifdef PIPE_DFF_OCC_EN
    , .occupancy(occ_c)
`endif
  );

  function automatic int st_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

`ifdef PIPE_DFF_OCC_EN
  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ_a);
      1:       return int'(occ_b);
      default: return int'(occ_c);
    endcase
  endfunction
`endif

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", nm, k, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_ov(input int k);
    return (m_n[k] > 0) && (m_pos[k][0] == st_of(k) - 1);
  endfunction

  // A free slot anywhere means some bubble can collapse toward the input.
  function automatic logic m_ir(input int k);
    return !rst && !flush && ((m_n[k] < st_of(k)) || out_ready);
  endfunction

  task automatic m_update(input int k);
    int         s;
    int         nn;
    int         np [4];
    logic [7:0] nd [4];
    logic       ifire;
    logic       ofire;
    logic       mv;
    s     = st_of(k);
    ofire = m_ov(k) && out_ready;
    ifire = in_valid && m_ir(k);
    if (k == 2) begin
      if (ofire) begin
        chk("sb_nonempty", k, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_data", k, 32'(s_od[k]), 32'(exp_q.pop_front()));
      end
      if (rst || flush) exp_q.delete();
      else if (ifire) exp_q.push_back(in_data);
    end
    nn = 0;
    // Word j has j older words above it; it moves if a free slot lies above it.
    for (int j = 0; j < m_n[k]; j++) begin
      mv = out_ready || ((s - 1 - m_pos[k][j]) > j);
      if (!(mv && m_pos[k][j] == s - 1)) begin
        np[nn] = mv ? m_pos[k][j] + 1 : m_pos[k][j];
        nd[nn] = m_dat[k][j];
        nn++;
      end
    end
    if (rst || flush) begin
      nn = 0;
    end else if (ifire) begin
      np[nn] = 0;
      nd[nn] = in_data;
      nn++;
    end
    m_n[k] = nn;
    for (int j = 0; j < nn; j++) begin
      m_pos[k][j] = np[j];
      m_dat[k][j] = nd[j];
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic fl, input logic iv, input logic [7:0] id,
                      input logic ordy);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      s_ir[k] = ir[k];
      s_ov[k] = ov[k];
      s_od[k] = od[k];
      chk("model_in_ready", k, 32'(ir[k]), 32'(m_ir(k)));
      chk("model_out_valid", k, 32'(ov[k]), 32'(m_ov(k)));
      if (m_ov(k)) chk("model_out_data", k, 32'(od[k]), 32'(m_dat[k][0]));
`ifdef PIPE_DFF_OCC_EN
      chk("model_occupancy", k, 32'(occ_of(k)), 32'(m_n[k]));
`endif
    end
    for (int k = 0; k < 3; k++) m_update(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 8'h00, ordy);
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic eir, input logic eov, input logic [7:0] eod);
    return '{iv: iv, id: id, ordy: ordy, eir: eir, eov: eov, eod: eod};
  endfunction

  vec_t tbl [15];

  initial begin
    for (int k = 0; k < 3; k++) m_n[k] = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: outputs idle and in_ready held low while rst is high.
    step(1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", k, 32'(s_ir[k]), 32'd0);
      chk("rst_out_valid", k, 32'(s_ov[k]), 32'd0);
      chk("rst_out_data", k, 32'(s_od[k]), 32'(RV));
    end

    // Back-to-back stream, then fill-and-stall, on the STAGES=2 instance.
    tbl[0]  = mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl[1]  = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl[2]  = mk(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11);
    tbl[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22);
    tbl[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33);
    tbl[5]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl[6]  = mk(1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00);
    tbl[7]  = mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00);
    tbl[8]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0);
    tbl[9]  = mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0);
    tbl[10] = mk(1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA0);
    tbl[11] = mk(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA1);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2);
    tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3);
    tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk("tbl_in_ready", 0, 32'(s_ir[0]), 32'(tbl[i].eir));
      chk("tbl_out_valid", 0, 32'(s_ov[0]), 32'(tbl[i].eov));
      if (tbl[i].eov) chk("tbl_out_data", 0, 32'(s_od[0]), 32'(tbl[i].eod));
    end

    // Bubble collapse on STAGES=4: one word runs to the end while stalled.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hB0, 1'b0);
    repeat (5) idle(1'b0);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
      chk("bubble_in_ready", 1, 32'(s_ir[1]), 32'd1);
      chk("bubble_head", 1, 32'(s_od[1]), 32'hB0);
    end
    step(1'b0, 1'b0, 1'b1, 8'hB4, 1'b0);
    chk("bubble_full_in_ready", 1, 32'(s_ir[1]), 32'd0);
`ifdef PIPE_DFF_OCC_EN
    chk("bubble_occupancy", 1, 32'(occ_b), 32'd4);
`endif
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("bubble_drain_valid", 1, 32'(s_ov[1]), 32'd1);
      chk("bubble_drain_data", 1, 32'(s_od[1]), 32'(8'hB0 + i));
    end
    idle(1'b1);
    chk("bubble_empty", 1, 32'(s_ov[1]), 32'd0);

    // Flush with the STAGES=4 pipe full and a word offered.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
    chk("flush_in_ready", 1, 32'(s_ir[1]), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
    chk("flush_out_valid", 1, 32'(s_ov[1]), 32'd0);
    chk("flush_data_kept", 1, 32'(s_od[1]), 32'hC0);
    chk("flush_reaccept", 1, 32'(s_ir[1]), 32'd1);
    for (int t = 1; t <= 4; t++) begin
      idle(1'b1);
      chk("flush_5a_valid", 1, 32'(s_ov[1]), 32'(t == 4));
      if (t == 4) chk("flush_5a_data", 1, 32'(s_od[1]), 32'h5A);
    end

    // Reset mid-stream together with flush, then nominal latency afterwards.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("midrst_in_ready", k, 32'(s_ir[k]), 32'd0);
      chk("midrst_out_valid", k, 32'(s_ov[k]), 32'd0);
      chk("midrst_out_data", k, 32'(s_od[k]), 32'(RV));
    end
    step(1'b0, 1'b0, 1'b1, 8'hD7, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      idle(1'b1);
      for (int k = 0; k < 3; k++) begin
        if (t <= st_of(k)) chk("postrst_valid", k, 32'(s_ov[k]), 32'(t == st_of(k)));
        if (t == st_of(k)) chk("postrst_data", k, 32'(s_od[k]), 32'hD7);
      end
    end

    // Random traffic; STAGES=1 also tracked by the exp_q scoreboard.
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 511) == 0), 1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
